// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared types for the register-transfer controller: opcodes, FSM states, default size.
// BUS_SETTLE_EN adds the SETTLE state used by MOV to let the bus settle before the load.
package reg_xfer_ctrl_pkg;

  localparam int NREG_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LDI = 2'b01,
    OP_MOV = 2'b10,
    OP_CLR = 2'b11
  } op_t;

`ifdef BUS_SETTLE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd2
  } state_t;
`endif

  // A single register still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_idx_onehot.sv
// Gated index-to-one-hot decoder; an out-of-range index yields all zeros.
module idx_onehot #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [W-1:0] idx,
  input  logic         gate,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = gate && (idx == W'(i));
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Moore controller sequencing LDI/MOV/CLR/NOP onto per-register enable strobes.
// BUS_SETTLE_EN: MOV spends one SETTLE cycle driving the bus before the load.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETTLE | MOV only: source drives the bus, no load yet
// EXEC   | enables for the captured command, done (and err) pulse
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  localparam int IDXW = idx_width(NREG)
) (
  input  logic            clk,
  input  logic            grst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_src,
  input  logic [IDXW-1:0] cmd_dst,
  output logic [NREG-1:0] rs1,
  output logic [NREG-1:0] rs2,
  output logic [NREG-1:0] ws1,
  output logic [NREG-1:0] lrst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [IDXW:0] NREG_W = (IDXW+1)'(NREG);

  state_t          state;
  op_t             op_q;
  logic [IDXW-1:0] src_q;
  logic [IDXW-1:0] dst_q;
  logic            ill_q;
  logic            cmd_illegal;

  function automatic logic idx_ok(input logic [IDXW-1:0] i);
    return {1'b0, i} < NREG_W;
  endfunction

  always_comb begin
    cmd_illegal = 1'b0;
    case (op_t'(cmd_op))
      OP_MOV:         cmd_illegal = (cmd_src == cmd_dst) || !idx_ok(cmd_src) || !idx_ok(cmd_dst);
      OP_LDI, OP_CLR: cmd_illegal = !idx_ok(cmd_dst);
      default:        cmd_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
      src_q <= '0;
      dst_q <= '0;
      ill_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            ill_q <= cmd_illegal;
`ifdef BUS_SETTLE_EN
            state <= (op_t'(cmd_op) == OP_MOV && !cmd_illegal) ? ST_SETTLE : ST_EXEC;
`else
            state <= ST_EXEC;
`endif
          end
        end
`ifdef BUS_SETTLE_EN
        ST_SETTLE: state <= ST_EXEC;
`endif
        ST_EXEC:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // All strobes decode from registered state/command only; illegal commands gate everything off.
  logic in_exec, legal, g_rs1, g_rs2, g_ws1, g_lrst;

  assign in_exec = (state == ST_EXEC);
  assign legal   = !ill_q;
  assign g_rs1   = in_exec && legal && (op_q == OP_LDI);
  assign g_lrst  = in_exec && legal && (op_q == OP_CLR);
  assign g_rs2   = in_exec && legal && (op_q == OP_MOV);
  assign g_ws1   = (state != ST_IDLE) && legal && (op_q == OP_MOV);

  idx_onehot #(.N(NREG), .W(IDXW)) u_rs1  (.idx(dst_q), .gate(g_rs1),  .onehot(rs1));
  idx_onehot #(.N(NREG), .W(IDXW)) u_rs2  (.idx(dst_q), .gate(g_rs2),  .onehot(rs2));
  idx_onehot #(.N(NREG), .W(IDXW)) u_ws1  (.idx(src_q), .gate(g_ws1),  .onehot(ws1));
  idx_onehot #(.N(NREG), .W(IDXW)) u_lrst (.idx(dst_q), .gate(g_lrst), .onehot(lrst));

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = in_exec;
  assign err       = in_exec && ill_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: per-cycle compare against a queue-based
// model of the expected output sequence of each command, plus literal spot checks.
module tb_reg_xfer_ctrl;

  localparam int N = 4;
`ifdef BUS_SETTLE_EN
  localparam bit SETTLE = 1'b1;
`else
  localparam bit SETTLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       grst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_src = 2'b00;
  logic [1:0] cmd_dst = 2'b00;
  logic [N-1:0] rs1, rs2, ws1, lrst;
  logic       busy, done, err;

  int checks = 0;
  int errs   = 0;
  bit chk_en = 1'b0;

  reg_xfer_ctrl #(.NREG(N)) dut (
    .clk(clk), .grst(grst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .rs1(rs1), .rs2(rs2), .ws1(ws1), .lrst(lrst),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready, bsy, dn, er;
    logic [N-1:0] r1, r2, w1, lr;
  } obs_t;

  // Each queue entry is the output vector of one future busy cycle; empty queue means idle.
  obs_t q[$];

  function automatic obs_t idle_obs();
    obs_t r;
    r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic obs_t busy_obs();
    obs_t r;
    r = '0;
    r.bsy = 1'b1;
    return r;
  endfunction

  function automatic obs_t expected();
    return (q.size() == 0) ? idle_obs() : q[0];
  endfunction

  function automatic void model_edge(input bit g, input bit v, input logic [1:0] op,
                                     input logic [1:0] s, input logic [1:0] d);
    obs_t a, b;
    if (g) begin
      q.delete();
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (v) begin
      b = busy_obs();
      b.dn = 1'b1;
      case (op)
        2'b00: q.push_back(b);
        2'b01: begin b.r1 = N'(1) << d; q.push_back(b); end
        2'b11: begin b.lr = N'(1) << d; q.push_back(b); end
        default: begin
          if (s == d) begin
            b.er = 1'b1;
            q.push_back(b);
          end else begin
            if (SETTLE) begin
              a = busy_obs();
              a.w1 = N'(1) << s;
              q.push_back(a);
            end
            b.w1 = N'(1) << s;
            b.r2 = N'(1) << d;
            q.push_back(b);
          end
        end
      endcase
    end
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    obs_t act, exp_o;
    if (chk_en) begin
      act   = {cmd_ready, busy, done, err, rs1, rs2, ws1, lrst};
      exp_o = expected();
      checks++;
      if (act !== exp_o) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t got rdy=%b busy=%b done=%b err=%b rs1=%b rs2=%b ws1=%b lrst=%b exp rdy=%b busy=%b done=%b err=%b rs1=%b rs2=%b ws1=%b lrst=%b",
                 $time, act.ready, act.bsy, act.dn, act.er, act.r1, act.r2, act.w1, act.lr,
                 exp_o.ready, exp_o.bsy, exp_o.dn, exp_o.er, exp_o.r1, exp_o.r2, exp_o.w1, exp_o.lr);
      end
      checks++;
      if ($countones(ws1) > 1) begin
        errs++;
        $display("FAIL ws1_onehot t=%0t got=%b exp=at most one bit", $time, ws1);
      end
    end
  end

  task automatic tick(input bit g, input bit v, input logic [1:0] op,
                      input logic [1:0] s, input logic [1:0] d);
    grst = g; cmd_valid = v; cmd_op = op; cmd_src = s; cmd_dst = d;
    @(posedge clk);
    #1;
    model_edge(g, v, op, s, d);
    if (g) chk_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  initial begin
    logic [1:0] ops [4];
    logic [1:0] srcs[4];
    logic [1:0] dsts[4];
    int idx, cyc;
    bit acc;

    // Reset, then idle with no command.
    repeat (3) tick(1, 1, 2'b01, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enables", {rs1, rs2, ws1, lrst}, 0);

    // LDI dst=2.
    tick(0, 1, 2'b01, 0, 2);
    chk("ldi_rs1", rs1, 32'b0100);
    chk("ldi_done", done, 1);
    chk("ldi_ready_low", cmd_ready, 0);
    tick(0, 0, 0, 0, 0);
    chk("ldi_ready_back", cmd_ready, 1);

    // MOV src=0 dst=3.
    tick(0, 1, 2'b10, 0, 3);
    if (SETTLE) begin
      chk("mov_settle_ws1", ws1, 32'b0001);
      chk("mov_settle_rs2", rs2, 0);
      chk("mov_settle_done", done, 0);
      tick(0, 0, 0, 0, 0);
    end
    chk("mov_exec_ws1", ws1, 32'b0001);
    chk("mov_exec_rs2", rs2, 32'b1000);
    chk("mov_exec_done", done, 1);
    tick(0, 0, 0, 0, 0);

    // MOV src==dst is illegal.
    tick(0, 1, 2'b10, 1, 1);
    chk("mov_ill_enables", {rs1, rs2, ws1, lrst}, 0);
    chk("mov_ill_done", done, 1);
    chk("mov_ill_err", err, 1);
    tick(0, 0, 0, 0, 0);

    // Reset during the first cycle of a MOV.
    tick(0, 1, 2'b10, 0, 3);
    tick(1, 1, 2'b01, 0, 1);
    chk("abort_enables", {rs1, rs2, ws1, lrst}, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    tick(0, 0, 0, 0, 0);

    // Back-to-back with cmd_valid held high.
    ops  = '{2'b01, 2'b11, 2'b10, 2'b00};
    srcs = '{2'd0, 2'd0, 2'd1, 2'd0};
    dsts = '{2'd1, 2'd2, 2'd3, 2'd0};
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      acc = (q.size() == 0);
      tick(0, 1, ops[idx], srcs[idx], dsts[idx]);
      cyc++;
      if (acc) idx++;
    end
    chk("b2b_cycles", cyc, SETTLE ? 8 : 7);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
